// File: rtl/evt2_pkg.sv
// Shared EVT 2.0 definitions: packet types, raw word field positions and the
// event payload carried between decoder stages.
package evt2_pkg;

  typedef enum logic [3:0] {
    CD_OFF      = 4'h0,
    CD_ON       = 4'h1,
    TIME_HIGH   = 4'h8,
    EXT_TRIGGER = 4'hA,
    OTHERS      = 4'hE,
    CONTINUED   = 4'hF
  } evt2_type_e;

  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 28;
  localparam int TS_MSB   = 27;
  localparam int TS_LSB   = 22;
  localparam int X_MSB    = 21;
  localparam int X_LSB    = 11;
  localparam int Y_MSB    = 10;
  localparam int Y_LSB    = 0;
  localparam int TH_MSB   = 27;
  localparam int TH_LSB   = 0;

  // Fields are sized for the widest legal configuration; each stage keeps
  // only the low bits its own parameters call for.
  localparam int EVT_XY_W = 11;
  localparam int EVT_TS_W = 34;

  typedef struct packed {
    logic [EVT_XY_W-1:0] x;
    logic [EVT_XY_W-1:0] y;
    logic                pol;
    logic [EVT_TS_W-1:0] ts;
  } evt_t;

endpackage

// File: rtl/evt2_skid_fifo.sv
// Two-entry order-preserving FIFO with valid/ready on both sides; accepts
// whenever it is not full, independent of the downstream ready.
module evt2_skid_fifo
  import evt2_pkg::*;
#(
  parameter int W = $bits(evt_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/evt2_roi_decoder.sv
// EVT 2.0 decoder: timestamp rebuild, ROI and polarity filtering, grid
// downsampling and saturating debug counters, buffered by a 2-entry FIFO.
module evt2_roi_decoder
  import evt2_pkg::*;
#(
  parameter int SENSOR_W   = 320,
  parameter int SENSOR_H   = 320,
  parameter int GRID_BITS  = 4,
  parameter int SHIFT      = 4,
  parameter int TS_BITS    = 16,
  parameter int CNT_W      = 16,
  parameter int REQUIRE_TH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [10:0]          roi_x_min,
  input  logic [10:0]          roi_x_max,
  input  logic [10:0]          roi_y_min,
  input  logic [10:0]          roi_y_max,
  input  logic [1:0]           pol_en,
  output logic [GRID_BITS-1:0] out_x,
  output logic [GRID_BITS-1:0] out_y,
  output logic                 out_pol,
  output logic [TS_BITS-1:0]   out_ts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     evt_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [10:0] SENSOR_W_L = 11'(SENSOR_W);
  localparam logic [10:0] SENSOR_H_L = 11'(SENSOR_H);
  localparam logic [10:0] GRID_MAX   = 11'((1 << GRID_BITS) - 1);

  function automatic logic [GRID_BITS-1:0] grid_sat(input logic [10:0] raw,
                                                   input logic [10:0] lo);
    logic [10:0] rel;
    rel = (raw - lo) >> SHIFT;
    if (rel > GRID_MAX) return GRID_MAX[GRID_BITS-1:0];
    return rel[GRID_BITS-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                              input logic en);
    if (en && !(&c)) return c + CNT_W'(1);
    return c;
  endfunction

  logic [27:0]          time_high;
  logic                 th_seen;

  logic [3:0]           typ_p0;
  logic [10:0]          x_p0;
  logic [10:0]          y_p0;
  logic [5:0]           tsl_p0;
  logic                 acc_p0;
  logic                 is_cd_p0;
  logic                 pol_p0;
  logic                 bad_p0;
  logic                 gate_p0;
  logic                 pol_ok_p0;
  logic                 roi_ok_p0;
  logic                 known_p0;
  logic                 th_p0;
  logic                 vld_p0;
  logic                 drop_p0;
  logic                 err_p0;
  evt_t                 evt_p0;

  logic [$bits(evt_t)-1:0] head_raw_p1;
  evt_t                    head_p1;
  logic                    unused_hi;

  // Stage p0: decode and classify the word offered this cycle
  always_comb begin
    typ_p0    = in_data[TYPE_MSB:TYPE_LSB];
    x_p0      = in_data[X_MSB:X_LSB];
    y_p0      = in_data[Y_MSB:Y_LSB];
    tsl_p0    = in_data[TS_MSB:TS_LSB];
    acc_p0    = in_valid & in_ready;
    is_cd_p0  = (typ_p0 == CD_OFF) || (typ_p0 == CD_ON);
    pol_p0    = typ_p0[0];
    known_p0  = is_cd_p0 || (typ_p0 == TIME_HIGH) || (typ_p0 == EXT_TRIGGER)
                || (typ_p0 == OTHERS) || (typ_p0 == CONTINUED);
    bad_p0    = (x_p0 >= SENSOR_W_L) || (y_p0 >= SENSOR_H_L);
    gate_p0   = (REQUIRE_TH != 0) && !th_seen;
    pol_ok_p0 = pol_en[pol_p0];
    roi_ok_p0 = (x_p0 >= roi_x_min) && (x_p0 <= roi_x_max)
                && (y_p0 >= roi_y_min) && (y_p0 <= roi_y_max);
    th_p0     = acc_p0 && (typ_p0 == TIME_HIGH);
    vld_p0    = acc_p0 && is_cd_p0 && !bad_p0 && !gate_p0 && pol_ok_p0 && roi_ok_p0;
    drop_p0   = acc_p0 && is_cd_p0 && !bad_p0 && (gate_p0 || !pol_ok_p0 || !roi_ok_p0);
    err_p0    = acc_p0 && ((is_cd_p0 && bad_p0) || !known_p0);

    evt_p0     = '0;
    evt_p0.x   = EVT_XY_W'(grid_sat(x_p0, roi_x_min));
    evt_p0.y   = EVT_XY_W'(grid_sat(y_p0, roi_y_min));
    evt_p0.pol = pol_p0;
    evt_p0.ts  = {time_high, tsl_p0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_high <= '0;
      th_seen   <= 1'b0;
      evt_cnt   <= '0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (th_p0) begin
        time_high <= in_data[TH_MSB:TH_LSB];
        th_seen   <= 1'b1;
      end
      evt_cnt  <= sat_inc(evt_cnt, vld_p0);
      drop_cnt <= sat_inc(drop_cnt, drop_p0);
      err_cnt  <= sat_inc(err_cnt, err_p0);
    end
  end

  // Stage p1: buffered events presented to the downstream consumer
  evt2_skid_fifo #(
    .W($bits(evt_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (evt_p0),
    .in_valid (vld_p0),
    .in_ready (in_ready),
    .out_data (head_raw_p1),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign head_p1   = head_raw_p1;
  assign out_x     = head_p1.x[GRID_BITS-1:0];
  assign out_y     = head_p1.y[GRID_BITS-1:0];
  assign out_pol   = head_p1.pol;
  assign out_ts    = head_p1.ts[TS_BITS-1:0];
  assign unused_hi = ^{head_p1.x >> GRID_BITS, head_p1.y >> GRID_BITS,
                       head_p1.ts >> TS_BITS};

endmodule

// File: doc/evt2_roi_decoder.md
Name: evt2_roi_decoder

Overview:
Parametrised next-generation EVT 2.0 decoder for the GenX320 front end. It consumes 32-bit EVT 2.0 words from the input FIFO and rebuilds the timestamp. It applies a runtime ROI window and a polarity filter, then downsamples ROI-relative coordinates to a 2^GRID_BITS grid. Events leave through a valid/ready output with a 2-entry skid buffer, so downstream accumulators can stall it; saturating statistics counters are exposed for debug.

Parameters:
SENSOR_W, 320, raw X extent; x_raw >= SENSOR_W is a malformed event.
SENSOR_H, 320, raw Y extent; y_raw >= SENSOR_H is a malformed event.
GRID_BITS, 4, output grid coordinate width per axis.
SHIFT, 4, right-shift applied to ROI-relative coordinates.
TS_BITS, 16, output timestamp width; must be >= 7 and <= 34.
CNT_W, 16, statistics counter width.
REQUIRE_TH, 1, when 1, CD events seen before the first TIME_HIGH are dropped.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
in_data  in  32  EVT 2.0 word
in_valid  in  1  word available
in_ready  out  1  word consumed when in_valid & in_ready
roi_x_min  in  11  ROI inclusive lower X bound (raw pixels)
roi_x_max  in  11  ROI inclusive upper X bound
roi_y_min  in  11  ROI inclusive lower Y bound
roi_y_max  in  11  ROI inclusive upper Y bound
pol_en  in  2  bit0 passes OFF events, bit1 passes ON events
out_x  out  GRID_BITS  grid X
out_y  out  GRID_BITS  grid Y
out_pol  out  1  1=ON, 0=OFF
out_ts  out  TS_BITS  reconstructed timestamp
out_valid  out  1  event available
out_ready  in  1  downstream accepts
evt_cnt  out  CNT_W  events pushed to output, saturating
drop_cnt  out  CNT_W  events dropped by ROI, polarity or TIME_HIGH gating, saturating
err_cnt  out  CNT_W  malformed CD events plus unknown packet types, saturating

Behaviour:
- Reset (asynchronous): time_high=0, th_seen=0, skid buffer empty, out_valid=0, out_x/out_y/out_pol/out_ts=0, all counters=0. A reset mid-stream discards any buffered events.
- Acceptance: in_ready = (occupancy < 2). The word is consumed on in_valid & in_ready.
- Packet types are fields [31:28]:
  - 0x8 TIME_HIGH: time_high <= in_data[27:0]; th_seen <= 1.
  - 0x0/0x1 CD events: classified as below.
  - 0xA, 0xE, 0xF: consumed silently with no counter change.
  - Any other type: consumed; err_cnt+1.
- CD classification is done on the accepted word, in this priority order:
  1. x_raw >= SENSOR_W or y_raw >= SENSOR_H: err_cnt+1.
  2. REQUIRE_TH=1 and th_seen=0: drop_cnt+1.
  3. Polarity bit clear in pol_en: drop_cnt+1.
  4. Outside ROI (x<min, x>max, y<min or y>max): drop_cnt+1.
  5. Otherwise push into the skid buffer; evt_cnt+1.
- Grid coordinates: gx = min((x_raw - roi_x_min) >> SHIFT, 2^GRID_BITS-1). gy is computed the same way. The subtraction is 11-bit and is never negative because of step 4.
- Timestamp: out_ts = low TS_BITS of {time_high, ts_lsb[27:22]}. TIME_HIGH and CD words are never accepted in the same cycle, so each event uses the time_high value registered before it.
- Latency: an accepted word with an empty buffer gives out_valid=1 on the next clock edge. Throughput is 1 event/cycle while out_ready=1.
- Skid buffer: a 2-entry FIFO that preserves order.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Output fields are stable while out_valid=1 and out_ready=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- ROI and pol_en are sampled on the accept cycle. Changing them never affects events already buffered.
- If roi_x_min > roi_x_max, no event lies inside the ROI, so every event is dropped.

Decomposition:
- Package evt2_pkg holds:
  - the packet-type constants (CD_OFF, CD_ON, TIME_HIGH, EXT_TRIGGER, OTHERS, CONTINUED);
  - the raw field bit positions;
  - a parametrised-width event struct {x, y, pol, ts} used by the FIFO payload.
- Sub-module evt2_skid_fifo: a 2-deep FIFO with valid/ready on both sides and asynchronous reset, reusable by other event stages.

Test Plan:
- Flow setup: rst pulse, ROI 0..319 both axes, pol_en=2'b11, out_ready=1.
- TIME_HIGH and ON event: send 0x80000003 then 0x114320C8 (CD_ON, ts_lsb=5, x=100, y=200) -> one cycle later out_valid=1, out_x=6, out_y=12, out_pol=1, out_ts=197, evt_cnt=1.
- TIME_HIGH gating: after reset, send a CD_OFF with x=16, y=16 before any TIME_HIGH -> no output, drop_cnt=1. Send TIME_HIGH 0x80000000 then the same event -> out_x=1, out_y=1, out_pol=0.
- Clamp and malformed coordinates: x=319, y=0 -> out_x=15. x=330 -> no output, err_cnt+1. Type 0x5 word -> err_cnt+1. Type 0xE word -> no counter change.
- ROI and polarity: ROI x 160..239, y 0..319, pol_en=2'b10. ON event at x=200 -> out_x=2. ON event at x=100 -> drop. OFF event at x=200 -> drop. Result drop_cnt=2.
- Backpressure and reset: out_ready=0, offer 3 valid events -> in_ready=0 after the 2nd is accepted. Raise out_ready -> events emerge in order and the 3rd is accepted. Assert rst asynchronously while 2 events are buffered -> out_valid=0 immediately and all counters=0.
